// File: rtl/andor_bist.sv
// Built-in self-test controller for a 4-input AND-OR cell, y = (a & b) | (c & d).
// It drives all 16 input vectors, holds each one for DWELL cycles, samples the
// cell response on the last dwell cycle and accumulates a saturating error count
// along with the first failing vector.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start; outputs at reset values
// RUN   | walking vectors 0..15, busy=1, sampling y_in every DWELL
// DONE  | run finished; results held until the next start or reset
module andor_bist #(
  parameter int DWELL = 20,
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       vec_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid
);

  // A one-cycle dwell still needs a 1-bit counter that simply stays at zero.
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DW_W-1:0] dwell_cnt, dwell_nxt;
  logic [3:0]      vec_nxt;
  logic            busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt, err_upd;
  logic [3:0]      ffv_nxt;
  logic            ffvalid_nxt;
  logic            exp_y, sample, mismatch;

  // Register every piece of state; reset wins over any other event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      dwell_cnt        <= '0;
      vec_out          <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= 4'd0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_nxt;
      dwell_cnt        <= dwell_nxt;
      vec_out          <= vec_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
      err_count        <= err_nxt;
      first_fail_vec   <= ffv_nxt;
      first_fail_valid <= ffvalid_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell_cnt;
    vec_nxt     = vec_out;
    busy_nxt    = busy;
    done_nxt    = done;
    pass_nxt    = pass;
    err_nxt     = err_count;
    ffv_nxt     = first_fail_vec;
    ffvalid_nxt = first_fail_valid;

    exp_y    = (vec_out[3] & vec_out[2]) | (vec_out[1] & vec_out[0]);
    sample   = (dwell_cnt == DWELL_LAST);
    mismatch = sample && (y_in != exp_y);
    // Saturating increment; pass on the final edge must see this edge's error.
    err_upd  = (mismatch && (err_count != ERR_MAX)) ? err_count + 1'b1 : err_count;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt   = RUN;
          busy_nxt    = 1'b1;
          vec_nxt     = 4'd0;
          dwell_nxt   = '0;
          err_nxt     = '0;
          ffv_nxt     = 4'd0;
          ffvalid_nxt = 1'b0;
          done_nxt    = 1'b0;
          pass_nxt    = 1'b0;
        end
      end
      RUN: begin
        if (sample) begin
          err_nxt = err_upd;
          if (mismatch && !first_fail_valid) begin
            ffv_nxt     = vec_out;
            ffvalid_nxt = 1'b1;
          end
          if (vec_out == 4'd15) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            vec_nxt   = 4'd0;
            pass_nxt  = (err_upd == '0);
          end else begin
            vec_nxt   = vec_out + 4'd1;
            dwell_nxt = '0;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_andor_bist.sv
// Bench for andor_bist: three instances (DWELL=20/ERR_W=5, DWELL=20/ERR_W=3,
// DWELL=1/ERR_W=5), each driven by a configurable model of the AND-OR cell.
// A run-level model predicts outputs from elapsed cycles since start.
module tb_andor_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [3];
  logic       start [3];
  logic       y_in  [3];
  logic [3:0] vec_a [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       pass_a [3];
  logic [3:0] ffv_a [3];
  logic       ffval_a [3];
  logic [4:0] err_a [3];
  logic [4:0] errc0, errc2;
  logic [2:0] errc1;
  int         mode [3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  localparam int D    [3] = '{20, 20, 1};
  localparam int EMAX [3] = '{31, 7, 31};

  andor_bist #(.DWELL(20), .ERR_W(5)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .vec_out(vec_a[0]), .y_in(y_in[0]),
    .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .err_count(errc0),
    .first_fail_vec(ffv_a[0]), .first_fail_valid(ffval_a[0]));

  andor_bist #(.DWELL(20), .ERR_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .vec_out(vec_a[1]), .y_in(y_in[1]),
    .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .err_count(errc1),
    .first_fail_vec(ffv_a[1]), .first_fail_valid(ffval_a[1]));

  andor_bist #(.DWELL(1), .ERR_W(5)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .vec_out(vec_a[2]), .y_in(y_in[2]),
    .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .err_count(errc2),
    .first_fail_vec(ffv_a[2]), .first_fail_valid(ffval_a[2]));

  assign err_a[0] = errc0;
  assign err_a[1] = {2'b00, errc1};
  assign err_a[2] = errc2;

  // Cell behaviour: 0 correct, 1 stuck at 0, 2 stuck at 1, 3 missing c&d term.
  function automatic logic cell_y(int m, logic [3:0] v);
    case (m)
      0: return (v >= 4'd12) || (v == 4'd3) || (v == 4'd7) || (v == 4'd11);
      1: return 1'b0;
      2: return 1'b1;
      default: return (v >= 4'd12);
    endcase
  endfunction

  function automatic bit truth(int v);
    return (v == 3) || (v == 7) || (v == 11) || (v >= 12);
  endfunction

  assign y_in[0] = cell_y(mode[0], vec_a[0]);
  assign y_in[1] = cell_y(mode[1], vec_a[1]);
  assign y_in[2] = cell_y(mode[2], vec_a[2]);

  // Run-level model: cycles since start determine the vector and sample points.
  bit       m_run [3];
  int       m_idx [3];
  int       m_errs [3];
  int       m_ffv [3];
  bit       m_ffval [3];
  bit       m_done [3];
  bit       m_pass [3];

  task automatic model_step(int i);
    int v;
    if (!rst_n[i]) begin
      m_run[i] = 0; m_idx[i] = 0; m_errs[i] = 0; m_ffv[i] = 0;
      m_ffval[i] = 0; m_done[i] = 0; m_pass[i] = 0;
    end else if (!m_run[i]) begin
      if (start[i]) begin
        m_run[i] = 1; m_idx[i] = 0; m_errs[i] = 0; m_ffv[i] = 0;
        m_ffval[i] = 0; m_done[i] = 0; m_pass[i] = 0;
      end
    end else begin
      m_idx[i]++;
      if (m_idx[i] % D[i] == 0) begin
        v = m_idx[i] / D[i] - 1;
        if (cell_y(mode[i], 4'(v)) != logic'(truth(v))) begin
          m_errs[i]++;
          if (!m_ffval[i]) begin
            m_ffv[i] = v;
            m_ffval[i] = 1;
          end
        end
        if (v == 15) begin
          m_run[i] = 0;
          m_done[i] = 1;
          m_pass[i] = (m_errs[i] == 0);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h want %0h", nm, i, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model on every instance.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy", i, busy_a[i], m_run[i]);
        chk("vec_out", i, vec_a[i], m_run[i] ? m_idx[i] / D[i] : 0);
        chk("err_count", i, err_a[i], (m_errs[i] > EMAX[i]) ? EMAX[i] : m_errs[i]);
        chk("ff_vec", i, ffv_a[i], m_ffv[i]);
        chk("ff_valid", i, ffval_a[i], m_ffval[i]);
        chk("done", i, done_a[i], m_done[i]);
        chk("pass", i, pass_a[i], m_pass[i]);
      end
    end
  end

  // Pulse start, optionally re-pulse when vec_out reaches mid_vec, count busy cycles.
  task automatic run(int i, int mid_vec, output int n);
    int k;
    bit pulsed;
    pulsed = 0;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    chk("start_busy", i, busy_a[i], 1);
    chk("start_done_clr", i, done_a[i], 0);
    chk("start_err_clr", i, err_a[i], 0);
    n = 0;
    k = 0;
    while (busy_a[i] && k < 2000) begin
      n++;
      k++;
      if (!pulsed && mid_vec >= 0 && vec_a[i] == 4'(mid_vec)) begin
        start[i] = 1'b1;
        pulsed = 1;
      end
      @(negedge clk) start[i] = 1'b0;
    end
    chk("run_done", i, done_a[i], 1);
  endtask

  initial begin
    int n;
    int k;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      mode[i]  = 0;
    end
    repeat (2) @(negedge clk);
    cmp_en = 1;
    chk("rst_vec", 0, vec_a[0], 0);
    chk("rst_busy", 0, busy_a[0], 0);
    chk("rst_done", 0, done_a[0], 0);
    chk("rst_err", 0, err_a[0], 0);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    repeat (2) @(negedge clk);

    // Correct cell, DWELL=20.
    mode[0] = 0;
    run(0, -1, n);
    chk("t1_busy_len", 0, n, 320);
    chk("t1_pass", 0, pass_a[0], 1);
    chk("t1_err", 0, err_a[0], 0);
    chk("t1_ffval", 0, ffval_a[0], 0);
    chk("t1_vec", 0, vec_a[0], 0);

    // Output stuck at 0.
    mode[0] = 1;
    run(0, -1, n);
    chk("t2_err", 0, err_a[0], 7);
    chk("t2_ffv", 0, ffv_a[0], 4'b0011);
    chk("t2_ffval", 0, ffval_a[0], 1);
    chk("t2_pass", 0, pass_a[0], 0);

    // Output stuck at 1, ERR_W=3 saturates.
    mode[1] = 2;
    run(1, -1, n);
    chk("t3_err", 1, err_a[1], 7);
    chk("t3_ffv", 1, ffv_a[1], 0);
    chk("t3_pass", 1, pass_a[1], 0);

    // Start repeated mid-run at vector 8.
    run(0, 8, n);
    chk("t5_busy_len", 0, n, 320);
    chk("t5_err", 0, err_a[0], 7);
    chk("t5_ffv", 0, ffv_a[0], 3);

    // Restart from DONE with a cell missing the c&d term.
    mode[0] = 3;
    run(0, -1, n);
    chk("t5b_err", 0, err_a[0], 3);
    chk("t5b_ffv", 0, ffv_a[0], 3);
    chk("t5b_pass", 0, pass_a[0], 0);

    // Reset while vector 5 is applied.
    mode[0] = 0;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    k = 0;
    while (vec_a[0] != 4'd5 && k < 500) begin
      k++;
      @(negedge clk);
    end
    chk("t4_reached5", 0, vec_a[0], 5);
    rst_n[0] = 1'b0;
    @(negedge clk) rst_n[0] = 1'b1;
    chk("t4_vec", 0, vec_a[0], 0);
    chk("t4_busy", 0, busy_a[0], 0);
    chk("t4_err", 0, err_a[0], 0);
    chk("t4_done", 0, done_a[0], 0);
    repeat (40) @(negedge clk);
    chk("t4_idle_busy", 0, busy_a[0], 0);
    chk("t4_idle_vec", 0, vec_a[0], 0);

    // DWELL=1, correct cell, then stuck at 0.
    mode[2] = 0;
    run(2, -1, n);
    chk("t6_busy_len", 2, n, 16);
    chk("t6_pass", 2, pass_a[2], 1);
    mode[2] = 1;
    run(2, -1, n);
    chk("t6b_err", 2, err_a[2], 7);
    chk("t6b_ffv", 2, ffv_a[2], 3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
